// File: rtl/pg_masked_prefix_adder.sv
// pg_masked_prefix_adder: pipelined two-share Boolean-masked Kogge-Stone adder built from DOM-indep AND gadgets.
module pg_masked_prefix_adder #(
  parameter int WIDTH = 8,
  localparam int LVL = $clog2(WIDTH),
  localparam int RND_W = WIDTH * (1 + 2 * LVL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_b0,
  input  logic [WIDTH-1:0] i_b1,
  input  logic [RND_W-1:0] i_rnd,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_s0,
  output logic [WIDTH-1:0] o_s1,
  output logic             o_c0,
  output logic             o_c1
);
  typedef logic [1:0][WIDTH-1:0] sh_t;
  // Each masked value is held as two terms per share (same-share part u, cross part v);
  // the share is u^v, compressed only at the next stage input.
  sh_t gu_q [LVL+1], gv_q [LVL+1], gu_d [LVL+1], gv_d [LVL+1], gc [LVL+1];
  sh_t pd_q [LVL+1], pd_d [LVL+1];
  sh_t pu_q [LVL], pv_q [LVL], pu_d [LVL], pv_d [LVL], pc [LVL];
  sh_t a_s, b_s, s_q, s_d;
  logic [1:0] c_q, c_d;
  logic [LVL+1:0] vld_q;
  logic stall;
  logic unused_rnd;
  assign a_s = {i_a1, i_a0};
  assign b_s = {i_b1, i_b0};
  assign stall = vld_q[LVL+1] & ~i_ready;
  assign o_ready = ~stall;
  assign o_valid = vld_q[LVL+1];
  assign o_s0 = s_q[0];
  assign o_s1 = s_q[1];
  assign o_c0 = c_q[0];
  assign o_c1 = c_q[1];
  assign unused_rnd = ^i_rnd;
  for (genvar j = 0; j < 2; j++) begin : g_sh
    assign pu_d[0][j] = a_s[j] ^ b_s[j];
    assign pv_d[0][j] = '0;
    assign pd_d[0][j] = a_s[j] ^ b_s[j];
    assign gu_d[0][j] = a_s[j] & b_s[j];
    assign gv_d[0][j] = (a_s[j] & b_s[1-j]) ^ i_rnd[WIDTH-1:0];
    assign s_d[j] = pd_q[LVL][j] ^ {gc[LVL][j][WIDTH-2:0], 1'b0};
    assign c_d[j] = gc[LVL][j][WIDTH-1];
    for (genvar k = 0; k <= LVL; k++) begin : g_cmp
      assign gc[k][j] = gu_q[k][j] ^ gv_q[k][j];
      if (k < LVL) begin : g_p
        assign pc[k][j] = pu_q[k][j] ^ pv_q[k][j];
      end
    end
    for (genvar k = 1; k <= LVL; k++) begin : g_lvl
      localparam int D = 2 ** (k - 1);
      assign pd_d[k][j] = pd_q[k-1][j];
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int RG = WIDTH + 2 * WIDTH * (k - 1) + 2 * i;
        if (i >= D) begin : g_op
          assign gu_d[k][j][i] = gc[k-1][j][i] ^ (pc[k-1][j][i] & gc[k-1][j][i-D]);
          assign gv_d[k][j][i] = (pc[k-1][j][i] & gc[k-1][1-j][i-D]) ^ i_rnd[RG];
          if (k < LVL) begin : g_pp
            assign pu_d[k][j][i] = pc[k-1][j][i] & pc[k-1][j][i-D];
            assign pv_d[k][j][i] = (pc[k-1][j][i] & pc[k-1][1-j][i-D]) ^ i_rnd[RG+1];
          end
        end else begin : g_pass
          assign gu_d[k][j][i] = gc[k-1][j][i];
          assign gv_d[k][j][i] = 1'b0;
          if (k < LVL) begin : g_pp
            assign pu_d[k][j][i] = pc[k-1][j][i];
            assign pv_d[k][j][i] = 1'b0;
          end
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      gu_q <= '{default: '0};
      gv_q <= '{default: '0};
      pu_q <= '{default: '0};
      pv_q <= '{default: '0};
      pd_q <= '{default: '0};
      s_q <= '0;
      c_q <= '0;
    end else if (!stall) begin
      vld_q <= {vld_q[LVL:0], i_valid};
      gu_q <= gu_d;
      gv_q <= gv_d;
      pu_q <= pu_d;
      pv_q <= pv_d;
      pd_q <= pd_d;
      s_q <= s_d;
      c_q <= c_d;
    end
  end
endmodule

// File: tb/tb_pg_masked_prefix_adder.sv
// tb_pg_masked_prefix_adder: directed and randomized checks of the masked adder, unmasking shares against a+b.
module tb_pg_masked_prefix_adder;
  localparam int W = 8;
  localparam int RW = W * (1 + 2 * $clog2(W));
  logic clk = 1'b0;
  logic rst_n, i_valid, o_ready, o_valid, i_ready, o_c0, o_c1;
  logic [W-1:0] i_a0, i_a1, i_b0, i_b1, o_s0, o_s1;
  logic [RW-1:0] i_rnd;
  int checks = 0;
  int errors = 0;

  pg_masked_prefix_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a0(i_a0), .i_a1(i_a1), .i_b0(i_b0), .i_b1(i_b1), .i_rnd(i_rnd),
    .o_valid(o_valid), .i_ready(i_ready), .o_s0(o_s0), .o_s1(o_s1), .o_c0(o_c0), .o_c1(o_c1)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  function automatic logic [RW-1:0] rnd_vec();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[RW-1:0];
  endfunction

  task automatic set_op(input logic [W-1:0] a, b, ma, mb, input logic [RW-1:0] r);
    i_a0 = a ^ ma;
    i_a1 = ma;
    i_b0 = b ^ mb;
    i_b1 = mb;
    i_rnd = r;
    i_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_one(input logic [W-1:0] a, b, ma, mb, input logic [RW-1:0] r,
                         output logic [W-1:0] s0, s1, output logic c0, c1, output int n);
    @(negedge clk);
    set_op(a, b, ma, mb, r);
    n = 0;
    do begin
      @(negedge clk);
      i_valid = 1'b0;
      n++;
    end while (!o_valid && n < 20);
    s0 = o_s0;
    s1 = o_s1;
    c0 = o_c0;
    c1 = o_c1;
    if (!o_valid) n = -1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl o_valid=%b o_ready=%b want 0/1", o_valid, o_ready);
    end
    checks++;
    if ({o_s0, o_s1, o_c0, o_c1} !== '0) begin
      errors++;
      $display("FAIL reset_data s0=%h s1=%h c0=%b c1=%b want all 0", o_s0, o_s1, o_c0, o_c1);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    logic [W-1:0] s0, s1;
    logic c0, c1;
    int n;
    run_one(8'hA5, 8'h5B, 8'h3C, 8'h3C, rnd_vec(), s0, s1, c0, c1, n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL single_latency got=%0d want=5", n);
    end
    checks++;
    if ({c0 ^ c1, s0 ^ s1} !== 9'h100) begin
      errors++;
      $display("FAIL single_sum got=%h want=100", {c0 ^ c1, s0 ^ s1});
    end
  endtask

  task automatic test_back_to_back;
    int t[$];
    logic [8:0] v[$];
    @(negedge clk);
    set_op(8'hFF, 8'h01, W'($urandom), W'($urandom), rnd_vec());
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (o_valid) begin
        t.push_back(n);
        v.push_back({o_c0 ^ o_c1, o_s0 ^ o_s1});
      end
      if (n == 1) set_op(8'h12, 8'h34, W'($urandom), W'($urandom), rnd_vec());
      else i_valid = 1'b0;
    end
    checks++;
    if (t.size() !== 2 || t[0] !== 5 || t[1] !== 6) begin
      errors++;
      $display("FAIL b2b_timing got n=%0d first=%0d second=%0d want 2 at 5,6", t.size(), t[0], t[1]);
    end
    checks++;
    if (v[0] !== 9'h100) begin
      errors++;
      $display("FAIL b2b_first got=%h want=100", v[0]);
    end
    checks++;
    if (v[1] !== 9'h046) begin
      errors++;
      $display("FAIL b2b_second got=%h want=046", v[1]);
    end
  endtask

  task automatic test_stall;
    logic [W-1:0] av[8], bv[8];
    logic [8:0] expq[$];
    logic [8:0] e;
    logic [W*2+2:0] hv;
    logic held;
    int idx, got, nst;
    for (int i = 0; i < 8; i++) begin
      av[i] = W'($urandom);
      bv[i] = W'($urandom);
    end
    idx = 0;
    got = 0;
    nst = 0;
    held = 1'b0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      if (held) begin
        checks++;
        if ({o_valid, o_c0, o_c1, o_s0, o_s1} !== hv) begin
          errors++;
          $display("FAIL stall_stable cycle=%0d got=%h want=%h", c, {o_valid, o_c0, o_c1, o_s0, o_s1}, hv);
        end
      end
      i_ready = !(c >= 6 && c < 9);
      if (idx < 8) set_op(av[idx], bv[idx], W'($urandom), W'($urandom), rnd_vec());
      else i_valid = 1'b0;
      #1;
      checks++;
      if (o_ready !== !(o_valid && !i_ready)) begin
        errors++;
        $display("FAIL stall_oready cycle=%0d got=%b want=%b", c, o_ready, !(o_valid && !i_ready));
      end
      held = o_valid && !i_ready;
      if (held) nst++;
      hv = {o_valid, o_c0, o_c1, o_s0, o_s1};
      if (o_valid && i_ready) begin
        e = (expq.size() > 0) ? expq.pop_front() : 9'h1FF;
        got++;
        checks++;
        if ({o_c0 ^ o_c1, o_s0 ^ o_s1} !== e) begin
          errors++;
          $display("FAIL stall_data idx=%0d got=%h want=%h", got - 1, {o_c0 ^ o_c1, o_s0 ^ o_s1}, e);
        end
      end
      if (i_valid && o_ready) begin
        expq.push_back({1'b0, av[idx]} + {1'b0, bv[idx]});
        idx++;
      end
    end
    checks++;
    if (got !== 8 || nst !== 3) begin
      errors++;
      $display("FAIL stall_count got=%0d stalls=%0d want 8/3", got, nst);
    end
  endtask

  task automatic test_reset_midflight;
    int stale;
    for (int n = 0; n <= 5; n++) begin
      @(negedge clk);
      if (n < 3) set_op(W'(8'h12 + n), 8'h34, W'($urandom), W'($urandom), rnd_vec());
      else i_valid = 1'b0;
    end
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre o_valid=%b want 1", o_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_s0, o_s1, o_c0, o_c1} !== '0) begin
      errors++;
      $display("FAIL midrst_clear v=%b s0=%h s1=%h c0=%b c1=%b want all 0", o_valid, o_s0, o_s1, o_c0, o_c1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL midrst_stale got=%0d valid cycles want=0", stale);
    end
  endtask

  task automatic test_rnd_zero;
    logic [W-1:0] s0a, s1a, s0, s1;
    logic c0a, c1a, c0, c1;
    int n;
    bit diff;
    run_one(8'h37, 8'h4A, 8'h00, 8'h00, '0, s0a, s1a, c0a, c1a, n);
    checks++;
    if (n !== 5 || {c0a ^ c1a, s0a ^ s1a} !== 9'h081) begin
      errors++;
      $display("FAIL rnd0_sum lat=%0d got=%h want=081", n, {c0a ^ c1a, s0a ^ s1a});
    end
    diff = 1'b0;
    for (int r = 0; r < 4; r++) begin
      run_one(8'h37, 8'h4A, W'($urandom), W'($urandom), rnd_vec(), s0, s1, c0, c1, n);
      checks++;
      if (n !== 5 || {c0 ^ c1, s0 ^ s1} !== 9'h081) begin
        errors++;
        $display("FAIL rnd_masked_sum run=%0d lat=%0d got=%h want=081", r, n, {c0 ^ c1, s0 ^ s1});
      end
      if ({s0, s1, c0, c1} !== {s0a, s1a, c0a, c1a}) diff = 1'b1;
    end
    checks++;
    if (!diff) begin
      errors++;
      $display("FAIL rnd_shares_differ got=identical want=differing");
    end
  endtask

  task automatic test_random;
    localparam int N = 1500;
    logic [8:0] expq[$];
    logic [8:0] e;
    logic [W-1:0] ca, cb;
    logic [W*2+2:0] hv;
    logic held;
    int idx, got;
    idx = 0;
    got = 0;
    held = 1'b0;
    for (int c = 0; c < 20000 && got < N; c++) begin
      @(negedge clk);
      if (held) begin
        checks++;
        if ({o_valid, o_c0, o_c1, o_s0, o_s1} !== hv) begin
          errors++;
          $display("FAIL rand_stable cycle=%0d got=%h want=%h", c, {o_valid, o_c0, o_c1, o_s0, o_s1}, hv);
        end
      end
      i_ready = ($urandom % 4) != 0;
      if (idx < N && ($urandom % 4) != 0) begin
        ca = W'($urandom);
        cb = W'($urandom);
        set_op(ca, cb, W'($urandom), W'($urandom), rnd_vec());
      end else i_valid = 1'b0;
      #1;
      held = o_valid && !i_ready;
      hv = {o_valid, o_c0, o_c1, o_s0, o_s1};
      if (o_valid && i_ready) begin
        e = (expq.size() > 0) ? expq.pop_front() : 9'h1FF;
        got++;
        checks++;
        if ({o_c0 ^ o_c1, o_s0 ^ o_s1} !== e) begin
          errors++;
          $display("FAIL rand_data idx=%0d got=%h want=%h", got - 1, {o_c0 ^ o_c1, o_s0 ^ o_s1}, e);
        end
      end
      if (i_valid && o_ready) begin
        expq.push_back({1'b0, ca} + {1'b0, cb});
        idx++;
      end
    end
    checks++;
    if (got !== N) begin
      errors++;
      $display("FAIL rand_count got=%0d want=%0d", got, N);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_a0 = '0;
    i_a1 = '0;
    i_b0 = '0;
    i_b1 = '0;
    i_rnd = '0;
    test_reset;
    test_single;
    idle(10);
    test_back_to_back;
    idle(10);
    test_stall;
    idle(10);
    test_reset_midflight;
    idle(10);
    test_rnd_zero;
    idle(10);
    test_random;
    idle(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
